// File: rtl/stage_if_if.sv
`default_nettype none
// ============================================================================
// Module      : stage_if_if
// Description : Bus bundle between the instruction-fetch stage and its
//               environment: I-cache/I-TLB lookup, refill handshake,
//               redirects from EX/MEM, and the registered IF/ID slot.
//               master = fetch stage, slave = environment (caches, ID, EX).
// Revision    : 1.0 - initial release
// ============================================================================
interface stage_if_if #(
  parameter int N_THREADS = 4
);
  localparam int TW = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;

  // I-cache / I-TLB lookup and refill
  logic [31:0]   ic_addr;
  logic          ic_hit;
  logic [31:0]   ic_data;
  logic          itlb_hit;
  logic          ic_fill_req;
  logic          ic_fill_done;

  // Redirects from later stages
  logic          redirect_valid;
  logic [TW-1:0] redirect_thread;
  logic [31:0]   redirect_pc;

  // IF/ID slot
  logic [31:0]   id_pc;
  logic [31:0]   id_instruction;
  logic [TW-1:0] id_thread;
  logic          id_itlb_miss;
  logic          id_icache_miss;

  modport master (
    output ic_addr, ic_fill_req,
    output id_pc, id_instruction, id_thread, id_itlb_miss, id_icache_miss,
    input  ic_hit, ic_data, itlb_hit, ic_fill_done,
    input  redirect_valid, redirect_thread, redirect_pc
  );

  modport slave (
    input  ic_addr, ic_fill_req,
    input  id_pc, id_instruction, id_thread, id_itlb_miss, id_icache_miss,
    output ic_hit, ic_data, itlb_hit, ic_fill_done,
    output redirect_valid, redirect_thread, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/stage_if.sv
`default_nettype none
// ============================================================================
// Module      : stage_if
// Description : Multithreaded instruction-fetch stage. One PC per thread,
//               round-robin pick of a READY thread, combinational I-TLB /
//               I-cache lookup, registered IF/ID slot. Threads park on
//               I-TLB misses (until redirected) and wait on a single
//               outstanding I-cache refill.
//               Optional: `define FETCH_PERF_EN adds per-thread saturating
//               fetched / stall counters (perf_fetched, perf_stall).
// Revision    : 1.0 - initial release
// ============================================================================
module stage_if #(
  parameter int          N_THREADS = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_1000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  wire logic   clk,
  input  wire logic   rst,
  stage_if_if.master  bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched [N_THREADS],
  output logic [31:0] perf_stall   [N_THREADS]
`endif
);

  localparam int TW = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;

  typedef enum logic [1:0] {
    TS_READY   = 2'd0,
    TS_WAIT_IC = 2'd1,
    TS_PARKED  = 2'd2
  } tstate_e;

  // (base + off) modulo N_THREADS, valid for non-power-of-two thread counts
  function automatic logic [TW-1:0] wrap_add(input logic [TW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % N_THREADS;
    return TW'(s);
  endfunction

  tstate_e       state_q [N_THREADS];
  tstate_e       state_d [N_THREADS];
  logic [31:0]   pc_q    [N_THREADS];
  logic [31:0]   pc_d    [N_THREADS];
  logic [TW-1:0] rr_q, rr_d;
  logic [TW-1:0] owner_q, owner_d;
  logic          busy_q, busy_d;

  logic [31:0]   id_pc_q, id_pc_d;
  logic [31:0]   id_instr_q, id_instr_d;
  logic [TW-1:0] id_thread_q, id_thread_d;
  logic          id_itlb_q, id_itlb_d;
  logic          id_icm_q, id_icm_d;

  logic [TW-1:0] sel;
  logic          any_ready;
  logic          redir_ok;
  logic          fetch;
  logic          do_hit;
  logic          do_tlb;
  logic          do_fill;
  logic          fill_ack;

  // Round-robin search for the first READY thread after the last one picked
  always_comb begin
    sel       = rr_q;
    any_ready = 1'b0;
    for (int i = 1; i <= N_THREADS; i++) begin
      if (!any_ready && state_q[wrap_add(rr_q, i)] == TS_READY) begin
        any_ready = 1'b1;
        sel       = wrap_add(rr_q, i);
      end
    end
  end

  // A redirect to the selected thread squashes its fetch entirely, so no
  // refill is requested on behalf of a PC that is about to be discarded.
  assign redir_ok = bus.redirect_valid && (int'(bus.redirect_thread) < N_THREADS);
  assign fetch    = any_ready && !(redir_ok && bus.redirect_thread == sel);
  assign do_hit   = fetch && bus.itlb_hit && bus.ic_hit;
  assign do_tlb   = fetch && !bus.itlb_hit;
  assign do_fill  = fetch && bus.itlb_hit && !bus.ic_hit && !busy_q;
  // A fill_done with no outstanding miss (e.g. after reset) is ignored
  assign fill_ack = bus.ic_fill_done && busy_q;

  assign bus.ic_addr     = any_ready ? pc_q[sel] : pc_q[rr_q];
  assign bus.ic_fill_req = do_fill;

  // Next thread state, PCs, refill ownership and the IF/ID slot contents
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rr_d    = any_ready ? sel : rr_q;
    busy_d  = busy_q;
    owner_d = owner_q;

    // Owner only resumes if nothing (e.g. a redirect) moved it meanwhile;
    // its PC is untouched so the refilled line is fetched again.
    if (fill_ack) begin
      busy_d = 1'b0;
      if (state_q[owner_q] == TS_WAIT_IC) begin
        state_d[owner_q] = TS_READY;
      end
    end

    if (do_hit) begin
      pc_d[sel] = pc_q[sel] + 32'd4;
    end
    if (do_tlb) begin
      state_d[sel] = TS_PARKED;
    end
    if (do_fill) begin
      busy_d       = 1'b1;
      owner_d      = sel;
      state_d[sel] = TS_WAIT_IC;
    end

    // Redirect wins over every other update to its thread; busy is left
    // alone so a redirected owner cannot start a second refill early.
    if (redir_ok) begin
      pc_d[bus.redirect_thread]    = bus.redirect_pc;
      state_d[bus.redirect_thread] = TS_READY;
    end

    id_pc_d     = 32'h0;
    id_instr_d  = NOP_INSTR;
    id_thread_d = '0;
    id_itlb_d   = 1'b0;
    id_icm_d    = 1'b1;
    if (do_hit) begin
      id_pc_d     = pc_q[sel];
      id_instr_d  = bus.ic_data;
      id_thread_d = sel;
      id_icm_d    = 1'b0;
    end else if (do_tlb) begin
      id_pc_d     = pc_q[sel];
      id_thread_d = sel;
      id_itlb_d   = 1'b1;
      id_icm_d    = 1'b0;
    end
  end

  // Register per-thread FSMs, pointers and the IF/ID slot
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < N_THREADS; t++) begin
        state_q[t] <= (t == 0) ? TS_READY : TS_PARKED;
        pc_q[t]    <= RESET_PC;
      end
      rr_q        <= TW'(N_THREADS - 1);
      owner_q     <= '0;
      busy_q      <= 1'b0;
      id_pc_q     <= 32'h0;
      id_instr_q  <= NOP_INSTR;
      id_thread_q <= '0;
      id_itlb_q   <= 1'b0;
      id_icm_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      id_thread_q <= id_thread_d;
      id_itlb_q   <= id_itlb_d;
      id_icm_q    <= id_icm_d;
    end
  end

  assign bus.id_pc          = id_pc_q;
  assign bus.id_instruction = id_instr_q;
  assign bus.id_thread      = id_thread_q;
  assign bus.id_itlb_miss   = id_itlb_q;
  assign bus.id_icache_miss = id_icm_q;

`ifdef FETCH_PERF_EN
  generate
    for (genvar t = 0; t < N_THREADS; t++) begin : g_perf
      logic [31:0] fetched_q;
      logic [31:0] stall_q;

      // Saturating per-thread counters of delivered instructions and stalls
      always_ff @(posedge clk) begin
        if (rst) begin
          fetched_q <= 32'h0;
          stall_q   <= 32'h0;
        end else begin
          if (do_hit && sel == TW'(t) && fetched_q != 32'hFFFF_FFFF) begin
            fetched_q <= fetched_q + 32'd1;
          end
          if (state_q[t] != TS_READY && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
          end
        end
      end

      assign perf_fetched[t] = fetched_q;
      assign perf_stall[t]   = stall_q;
    end
  endgenerate
`endif

endmodule
`default_nettype wire
